wb_sequencer: RTL and testbench
===============================

WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 Parameter EXC_REG, default 5'd31, destination register for exception writes.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 req  in  7  write request per source; bit i-1 = source i (mux data_i).
REQ-005 dst  in  35  packed destination registers; bits [5i-1:5i-5] = source i.
REQ-006 exc_req  in  1  exception write request (constant 227 path).
REQ-007 stall  in  1  freezes sequencing while high.
REQ-008 gnt  out  7  one-cycle grant per source.
REQ-009 exc_gnt  out  1  one-cycle exception grant.
REQ-010 wd_sel  out  3  write-data mux selector; 000 = constant 227, i = data_i.
REQ-011 write_reg  out  5  register-file write address.
REQ-012 reg_write  out  1  register-file write enable.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 FSM SHALL have states IDLE, SEL, WRITE.
REQ-015 IDLE: if exc_req or any req and not stall, latch winner index and destination, go SEL; else stay IDLE.
REQ-016 Priority: exc_req over all sources; among sources, round-robin starting at the source after the last granted one.
REQ-017 SEL: wd_sel = latched index, write_reg = latched destination, reg_write = 0; go WRITE unless stall, else hold SEL.
REQ-018 WRITE: wd_sel/write_reg held, reg_write = 1, gnt[winner] or exc_gnt = 1 for exactly this cycle; stall ignored; go IDLE.
REQ-019 Request-to-write latency SHALL be 2 cycles (req sampled in IDLE, reg_write in cycle +2) with stall low.
REQ-020 Exception winner SHALL use wd_sel = 000 and write_reg = EXC_REG.
REQ-021 Destination 0 SHALL suppress reg_write in WRITE while still issuing the grant.
REQ-022 Requester holds req and dst stable until granted and deasserts req the cycle after gnt; the sequencer SHALL NOT sample dst after IDLE.
REQ-023 Round-robin pointer SHALL update only in WRITE for source winners; exception grants leave it unchanged.
REQ-024 exc_req arriving in SEL or WRITE SHALL NOT preempt; it wins the next IDLE arbitration.
REQ-025 Minimum spacing between consecutive writes SHALL be 3 cycles (WRITE, IDLE, SEL).
REQ-026 Requests dropped before grant SHALL not be granted later; latched winner still completes once in SEL.

Reset
REQ-027 reset_n low SHALL force IDLE, gnt = 0, exc_gnt = 0, wd_sel = 000, write_reg = 0, reg_write = 0, busy = 0, pointer so source 1 has highest priority.
REQ-028 Reset during SEL or WRITE SHALL abort the write with no grant and no reg_write thereafter.
REQ-029 All outputs SHALL be registered.

Structure
REQ-030 Shared package SHALL hold selector constants (SEL_EXC = 3'b000, SEL_SRC1..SEL_SRC7), FSM state encoding, and EXC_REG default.
REQ-031 One sub-module rr_arbiter7 (7-input round-robin, combinational winner plus pointer input) SHALL be instantiated.

Verification
REQ-032 Single req[2] with dst 5'd9 -> wd_sel 011, write_reg 9, reg_write high 2 cycles later, gnt[2] one cycle.
REQ-033 req = 7'h7F held with re-assertion -> grant order 1,2,...,7,1; consecutive reg_write pulses exactly 3 cycles apart.
REQ-034 exc_req with req[0] simultaneous -> exc_gnt first, wd_sel 000, write_reg 31; source 1 granted next.
REQ-035 req[4] with dst 0 -> gnt[4] pulses, reg_write stays 0.
REQ-036 stall high 4 cycles in SEL -> SEL held, no reg_write; WRITE follows stall release by one cycle.
REQ-037 reset_n low during WRITE -> all outputs 0 next edge asynchronously, no gnt; normal arbitration after release.

Source files
------------

// File: rtl/wb_sequencer_pkg.sv
// wb_sequencer_pkg: shared selector constants, FSM encoding and defaults for wb_sequencer
package wb_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, SEL, WRITE} state_t;
  localparam logic [2:0] SEL_EXC  = 3'd0;
  localparam logic [2:0] SEL_SRC1 = 3'd1;
  localparam logic [2:0] SEL_SRC2 = 3'd2;
  localparam logic [2:0] SEL_SRC3 = 3'd3;
  localparam logic [2:0] SEL_SRC4 = 3'd4;
  localparam logic [2:0] SEL_SRC5 = 3'd5;
  localparam logic [2:0] SEL_SRC6 = 3'd6;
  localparam logic [2:0] SEL_SRC7 = 3'd7;
  localparam logic [4:0] EXC_REG_DEF = 5'd31;
  function automatic logic [6:0] src_onehot(input logic [2:0] sel);
    return sel == SEL_EXC ? 7'd0 : 7'(7'd1 << (sel - SEL_SRC1));
  endfunction
endpackage

// File: rtl/wb_sequencer_rr_arbiter7.sv
// rr_arbiter7: combinational 7-way round-robin winner, ptr names the highest-priority bit
module rr_arbiter7 (
  input  logic [6:0] req,
  input  logic [2:0] ptr,
  output logic       any,
  output logic [2:0] idx
);
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = 6; k >= 0; k--)
      if (req[(int'(ptr) + k) % 7]) idx = 3'((int'(ptr) + k) % 7);
  end
endmodule

// File: rtl/wb_sequencer.sv
// wb_sequencer: arbitrates write-back sources and the exception path into one register-file write port
module wb_sequencer
  import wb_sequencer_pkg::*;
#(
  parameter logic [4:0] EXC_REG = EXC_REG_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  req,
  input  logic [34:0] dst,
  input  logic        exc_req,
  input  logic        stall,
  output logic [6:0]  gnt,
  output logic        exc_gnt,
  output logic [2:0]  wd_sel,
  output logic [4:0]  write_reg,
  output logic        reg_write,
  output logic        busy
);
  state_t state, nxt;
  logic [2:0] ptr, widx, sidx, win_idx, cidx;
  logic [4:0] wdst, win_dst, cdst;
  logic       sany, go;
  logic [6:0] gnt_d;
  logic       exc_gnt_d, reg_write_d, busy_d;
  logic [2:0] wd_sel_d;
  logic [4:0] write_reg_d;

  rr_arbiter7 u_arb (.req(req), .ptr(ptr), .any(sany), .idx(sidx));

  assign go      = (exc_req || sany) && !stall;
  assign win_idx = exc_req ? SEL_EXC : sidx + 3'd1;
  assign win_dst = exc_req ? EXC_REG : dst[int'(sidx)*5 +: 5];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      widx  <= '0;
      wdst  <= '0;
      ptr   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && go) begin
        widx <= win_idx;
        wdst <= win_dst;
      end
      if (state == WRITE && widx != SEL_EXC) ptr <= widx == SEL_SRC7 ? 3'd0 : widx;
    end
  end

  always_comb
    nxt = state == IDLE ? (go ? SEL : IDLE) : state == SEL ? (stall ? SEL : WRITE) : IDLE;

  // outputs are registered, so they are derived from the state being entered
  always_comb begin
    cidx        = state == IDLE ? win_idx : widx;
    cdst        = state == IDLE ? win_dst : wdst;
    busy_d      = nxt != IDLE;
    wd_sel_d    = busy_d ? cidx : 3'd0;
    write_reg_d = busy_d ? cdst : 5'd0;
    reg_write_d = nxt == WRITE && cdst != 5'd0;
    gnt_d       = nxt == WRITE ? src_onehot(cidx) : 7'd0;
    exc_gnt_d   = nxt == WRITE && cidx == SEL_EXC;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt       <= '0;
      exc_gnt   <= 1'b0;
      wd_sel    <= '0;
      write_reg <= '0;
      reg_write <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt       <= gnt_d;
      exc_gnt   <= exc_gnt_d;
      wd_sel    <= wd_sel_d;
      write_reg <= write_reg_d;
      reg_write <= reg_write_d;
      busy      <= busy_d;
    end
  end
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: scenario tasks drive requests and queue expected writes; a negedge monitor scores grants
module tb_wb_sequencer;
  logic        clk = 0, reset_n = 0, exc_req = 0, stall = 0;
  logic [6:0]  req = '0;
  logic [34:0] dst = '0;
  logic [6:0]  gnt;
  logic        exc_gnt, reg_write, busy;
  logic [2:0]  wd_sel;
  logic [4:0]  write_reg;
  int checks = 0, failures = 0, cyc = 0;

  typedef struct {int src; logic [4:0] d;} exp_t;
  exp_t sb[$];

  wb_sequencer dut (.clk(clk), .reset_n(reset_n), .req(req), .dst(dst), .exc_req(exc_req),
                    .stall(stall), .gnt(gnt), .exc_gnt(exc_gnt), .wd_sel(wd_sel),
                    .write_reg(write_reg), .reg_write(reg_write), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n && (gnt != 0 || exc_gnt)) begin
      exp_t e;
      logic [6:0] eg;
      logic [4:0] ew;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_grant gnt=%b exc_gnt=%b", gnt, exc_gnt);
      end else begin
        e  = sb.pop_front();
        eg = e.src == 0 ? 7'd0 : 7'(7'd1 << (e.src - 1));
        ew = e.src == 0 ? 5'd31 : e.d;
        if ({gnt, exc_gnt, wd_sel, write_reg, reg_write} !== {eg, e.src == 0, 3'(e.src), ew, ew != 0}) begin
          failures++;
          $display("FAIL write_src%0d got gnt=%b exc=%b sel=%0d reg=%0d rw=%b want gnt=%b exc=%b sel=%0d reg=%0d rw=%b",
                   e.src, gnt, exc_gnt, wd_sel, write_reg, reg_write, eg, e.src == 0, e.src, ew, ew != 0);
        end
      end
    end else if (reset_n && reg_write) begin
      checks++;
      failures++;
      $display("FAIL reg_write_without_grant reg=%0d", write_reg);
    end
  end

  task automatic wait_write(output int t);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt != 0 || exc_gnt) begin
        t = cyc;
        return;
      end
    end
    checks++;
    failures++;
    t = cyc;
    $display("FAIL grant_timeout got none want grant within 30 cycles");
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, exc_gnt, wd_sel, write_reg, reg_write, busy} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs got %b want 0", {gnt, exc_gnt, wd_sel, write_reg, reg_write, busy});
    end
    reset_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int t, prev;
    for (int i = 0; i < 7; i++) dst[5*i +: 5] = 5'(i + 11);
    for (int i = 1; i <= 8; i++) sb.push_back('{i == 8 ? 1 : i, 5'((i == 8 ? 1 : i) + 10)});
    req = 7'h7F;
    for (int k = 0; k < 8; k++) begin
      wait_write(t);
      if (k > 0) begin
        checks++;
        if (t - prev !== 3) begin
          failures++;
          $display("FAIL write_spacing got %0d want 3", t - prev);
        end
      end
      prev = t;
    end
    req = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL b2b_pending got %0d want 0", sb.size());
    end
  endtask

  task automatic test_single;
    int c0, t;
    dst[14:10] = 5'd9;
    sb.push_back('{3, 5'd9});
    c0 = cyc;
    req = 7'b0000100;
    @(negedge clk);
    checks++;
    if ({wd_sel, write_reg, reg_write, busy} !== {3'b011, 5'd9, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL single_sel got sel=%b reg=%0d rw=%b busy=%b want 011 9 0 1", wd_sel, write_reg, reg_write, busy);
    end
    wait_write(t);
    req = '0;
    checks++;
    if (t - c0 !== 2) begin
      failures++;
      $display("FAIL single_latency got %0d want 2", t - c0);
    end
    @(negedge clk);
    checks++;
    if ({gnt, reg_write, busy} !== 9'd0) begin
      failures++;
      $display("FAIL single_one_cycle got gnt=%b rw=%b busy=%b want 0", gnt, reg_write, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_exception;
    int t;
    dst[4:0] = 5'd4;
    sb.push_back('{0, 5'd31});
    sb.push_back('{1, 5'd4});
    exc_req = 1;
    req = 7'b0000001;
    wait_write(t);
    exc_req = 0;
    checks++;
    if (exc_gnt !== 1'b1) begin
      failures++;
      $display("FAIL exc_first got exc_gnt=%b gnt=%b want exc_gnt=1", exc_gnt, gnt);
    end
    wait_write(t);
    req = '0;
    checks++;
    if (gnt !== 7'b0000001) begin
      failures++;
      $display("FAIL exc_then_src1 got gnt=%b want 0000001", gnt);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_dst_zero;
    int t;
    dst[24:20] = 5'd0;
    sb.push_back('{5, 5'd0});
    req = 7'b0010000;
    wait_write(t);
    req = '0;
    checks++;
    if ({gnt, reg_write} !== {7'b0010000, 1'b0}) begin
      failures++;
      $display("FAIL dst_zero got gnt=%b rw=%b want 0010000 0", gnt, reg_write);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall;
    dst[9:5] = 5'd7;
    sb.push_back('{2, 5'd7});
    req = 7'b0000010;
    @(negedge clk);
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({wd_sel, write_reg, reg_write, busy} !== {3'd2, 5'd7, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL stall_hold%0d got sel=%0d reg=%0d rw=%b busy=%b want 2 7 0 1", i, wd_sel, write_reg, reg_write, busy);
      end
    end
    stall = 0;
    @(negedge clk);
    req = '0;
    checks++;
    if ({reg_write, gnt} !== {1'b1, 7'b0000010}) begin
      failures++;
      $display("FAIL stall_release got rw=%b gnt=%b want 1 0000010", reg_write, gnt);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_write;
    int t;
    dst[4:0] = 5'd6;
    req = 7'b0000001;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    checks++;
    if ({gnt, exc_gnt, wd_sel, write_reg, reg_write, busy} !== 18'd0) begin
      failures++;
      $display("FAIL async_reset got %b want 0", {gnt, exc_gnt, wd_sel, write_reg, reg_write, busy});
    end
    @(negedge clk);
    sb.push_back('{1, 5'd6});
    reset_n = 1;
    wait_write(t);
    req = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL final_pending got %0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_single;
    test_exception;
    test_dst_zero;
    test_stall;
    test_reset_in_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
